// File: rtl/noc_pkg.sv
// Shared NoC types: coordinates, message types, header/flit layout and the
// first-hop routing decision used by injectors and routers alike.
package noc;

  localparam int FlitPayloadWidth = 64;
  localparam int CoordWidth       = 4;

  typedef struct packed {
    logic [CoordWidth-1:0] x;
    logic [CoordWidth-1:0] y;
  } xy_t;

  typedef enum logic [1:0] {
    MSG_READ  = 2'd0,
    MSG_WRITE = 2'd1,
    MSG_RESP  = 2'd2,
    MSG_INV   = 2'd3
  } msg_type_t;

  typedef enum logic [2:0] {
    goLocal = 3'd0,
    goEast  = 3'd1,
    goWest  = 3'd2,
    goNorth = 3'd3,
    goSouth = 3'd4
  } direction_t;

  // msg_type + source + destination + routing; the rest of the payload is reserved
  localparam int HeaderUsedBits = 2 + 4 * CoordWidth + 3;

  typedef struct packed {
    msg_type_t                                  msg_type;
    xy_t                                        source;
    xy_t                                        destination;
    direction_t                                 routing;
    logic [FlitPayloadWidth-HeaderUsedBits-1:0] reserved;
  } header_t;

  typedef struct packed {
    logic                        head;
    logic                        tail;
    logic [FlitPayloadWidth-1:0] payload;
  } flit_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_BODY   = 2'd2
  } inj_state_e;

  // X-first ring routing: only the x coordinate decides the first hop.
  function automatic direction_t first_hop_routing(input xy_t here, input xy_t dest);
    direction_t dir;
    if (here.x < dest.x)      dir = goEast;
    else if (here.x > dest.x) dir = goWest;
    else                      dir = goLocal;
    return dir;
  endfunction

endpackage

// File: rtl/noc_credit_counter.sv
// Credit counter toward a downstream buffer: starts full, dec on send,
// inc on returned credit, simultaneous inc/dec cancel, saturates at Max.
module noc_credit_counter #(
  parameter int Max            = 4,
  parameter bit AssertOverflow = 1'b1,
  localparam int W             = $clog2(Max + 1)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         avail_o,
  output logic         overflow_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count; a credit returned while already full is dropped (saturate).
  always_comb begin
    cnt_d      = cnt_q;
    overflow_o = inc_i && !dec_i && (cnt_q == W'(Max));
    if (inc_i && !dec_i && !overflow_o)           cnt_d = cnt_q + W'(1);
    else if (dec_i && !inc_i && (cnt_q != '0))    cnt_d = cnt_q - W'(1);
  end

  // Credit register, restored to full on reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= W'(Max);
    else       cnt_q <= cnt_d;
  end

  assign cnt_o   = cnt_q;
  assign avail_o = (cnt_q != '0);

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i || !AssertOverflow) !overflow_o);

endmodule

// File: rtl/noc_packet_injector.sv
// Source-side NoC interface: turns a request (header + req_len body words)
// into flits for the local router input, gated by buffer credits.
// Handshakes: req and data transfer on a cycle where valid && ready; valid
// must hold with stable payload until ready. out_valid has no ready; the
// router accepts every flit and returns one credit_in per freed slot.
module noc_packet_injector
  import noc::*;
#(
  parameter int DataWidth      = 64,
  parameter int MaxLen         = 16,
  parameter int Credits        = 4,
  parameter bit AssertOverflow = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  xy_t                          position,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  xy_t                          req_dest,
  input  msg_type_t                    req_msg_type,
  input  logic [$clog2(MaxLen+1)-1:0]  req_len,
  input  logic                         data_valid,
  output logic                         data_ready,
  input  logic [DataWidth-1:0]         data,
  output flit_t                        out_flit,
  output logic                         out_valid,
  input  logic                         credit_in,
  output logic                         busy,
  output inj_state_e                   dbg_state,
  output logic [$clog2(Credits+1)-1:0] dbg_credit_cnt,
  output logic                         credit_overflow
);

  localparam int LenWidth = $clog2(MaxLen + 1);
  localparam int CntWidth = $clog2(Credits + 1);

  inj_state_e          state_q, state_d;
  xy_t                 pos_q, dest_q;
  msg_type_t           msg_q;
  logic [LenWidth-1:0] len_q, remain_q, remain_d;
  flit_t               out_flit_q, out_flit_d;
  logic                out_valid_q, out_valid_d;
  logic                accept_req, emit, credit_avail;
  logic [CntWidth-1:0] credit_cnt;
  header_t             hdr;

  noc_credit_counter #(
    .Max            (Credits),
    .AssertOverflow (AssertOverflow)
  ) u_credits (
    .clk_i      (clk),
    .rst_i      (rst),
    .inc_i      (credit_in),
    .dec_i      (emit),
    .cnt_o      (credit_cnt),
    .avail_o    (credit_avail),
    .overflow_o (credit_overflow)
  );

  // Header word from the latched request and this tile's registered position.
  always_comb begin
    hdr             = '0;
    hdr.msg_type    = msg_q;
    hdr.source      = pos_q;
    hdr.destination = dest_q;
    hdr.routing     = first_hop_routing(pos_q, dest_q);
  end

  // FSM next state, handshakes and the flit to register this cycle.
  always_comb begin
    state_d     = state_q;
    remain_d    = remain_q;
    out_flit_d  = out_flit_q;
    out_valid_d = 1'b0;
    emit        = 1'b0;
    accept_req  = 1'b0;
    req_ready   = (state_q == ST_IDLE) && !rst;
    data_ready  = (state_q == ST_BODY) && credit_avail;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          accept_req = 1'b1;
          state_d    = ST_HEADER;
        end
      end
      ST_HEADER: begin
        if (credit_avail) begin
          emit               = 1'b1;
          out_valid_d        = 1'b1;
          out_flit_d.head    = 1'b1;
          out_flit_d.tail    = (len_q == '0);
          out_flit_d.payload = hdr;
          remain_d           = len_q;
          state_d            = (len_q == '0) ? ST_IDLE : ST_BODY;
        end
      end
      ST_BODY: begin
        if (data_valid && data_ready) begin
          emit               = 1'b1;
          out_valid_d        = 1'b1;
          out_flit_d.head    = 1'b0;
          out_flit_d.tail    = (remain_q == LenWidth'(1));
          out_flit_d.payload = data;
          remain_d           = remain_q - LenWidth'(1);
          if (remain_q == LenWidth'(1)) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, request latch, position sample and registered flit output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pos_q       <= '0;
      dest_q      <= '0;
      msg_q       <= MSG_READ;
      len_q       <= '0;
      remain_q    <= '0;
      out_flit_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= position;
      remain_q    <= remain_d;
      out_flit_q  <= out_flit_d;
      out_valid_q <= out_valid_d;
      if (accept_req) begin
        dest_q <= req_dest;
        msg_q  <= req_msg_type;
        len_q  <= req_len;
      end
    end
  end

  assign out_flit       = out_flit_q;
  assign out_valid      = out_valid_q;
  assign busy           = (state_q == ST_HEADER) || (state_q == ST_BODY);
  assign dbg_state      = state_q;
  assign dbg_credit_cnt = credit_cnt;

endmodule

// File: tb/tb_noc_packet_injector.sv
// Bench for noc_packet_injector: header-only vector table, hand sequences for
// body/credit/reset corners, then random traffic against a packet-level model.
module tb_noc_packet_injector;
  import noc::*;

  localparam int MaxLen  = 16;
  localparam int Credits = 4;
  localparam int LW      = $clog2(MaxLen + 1);
  localparam int CW      = $clog2(Credits + 1);
  localparam int FW      = $bits(flit_t);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  xy_t           position = '0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  xy_t           req_dest = '0;
  msg_type_t     req_msg_type = MSG_READ;
  logic [LW-1:0] req_len = '0;
  logic          data_valid = 1'b0;
  logic          data_ready;
  logic [63:0]   data = '0;
  flit_t         out_flit;
  logic          out_valid;
  logic          credit_in = 1'b0;
  logic          busy;
  inj_state_e    dbg_state;
  logic [CW-1:0] dbg_credit_cnt;
  logic          credit_overflow;

  int total = 0;
  int bad   = 0;

  noc_packet_injector #(
    .DataWidth (64), .MaxLen (MaxLen), .Credits (Credits), .AssertOverflow (1'b0)
  ) dut (
    .clk (clk), .rst (rst), .position (position),
    .req_valid (req_valid), .req_ready (req_ready), .req_dest (req_dest),
    .req_msg_type (req_msg_type), .req_len (req_len),
    .data_valid (data_valid), .data_ready (data_ready), .data (data),
    .out_flit (out_flit), .out_valid (out_valid), .credit_in (credit_in),
    .busy (busy), .dbg_state (dbg_state), .dbg_credit_cnt (dbg_credit_cnt),
    .credit_overflow (credit_overflow)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1; req_valid = 1'b0; data_valid = 1'b0; credit_in = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
  endtask

  // ---------------- helpers / reference rules ----------------
  function automatic xy_t xy(input int x, input int y);
    xy_t r;
    r.x = 4'(x);
    r.y = 4'(y);
    return r;
  endfunction

  function automatic direction_t spec_route(input xy_t p, input xy_t d);
    if (d.x > p.x) return goEast;
    if (d.x < p.x) return goWest;
    return goLocal;
  endfunction

  function automatic flit_t exp_header(input xy_t p, input xy_t d, input msg_type_t m,
                                       input direction_t r, input logic tail);
    header_t h;
    flit_t f;
    h = '0;
    h.msg_type = m; h.source = p; h.destination = d; h.routing = r;
    f.head = 1'b1; f.tail = tail; f.payload = h;
    return f;
  endfunction

  function automatic flit_t exp_body(input logic [63:0] w, input logic tail);
    flit_t f;
    f.head = 1'b0; f.tail = tail; f.payload = w;
    return f;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_req(input xy_t d, input msg_type_t m, input int len);
    int n = 0;
    req_valid = 1'b1; req_dest = d; req_msg_type = m; req_len = LW'(len);
    #1;
    while (!req_ready && n < 50) begin tick(); n++; end
    chk("req_handshake", req_ready, 1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic push_word(input logic [63:0] w);
    int n = 0;
    data_valid = 1'b1; data = w;
    #1;
    while (!data_ready && n < 50) begin tick(); n++; end
    chk("data_handshake", data_ready, 1);
    tick();
    data_valid = 1'b0;
  endtask

  task automatic return_credits(input int n);
    for (int i = 0; i < n; i++) begin
      credit_in = 1'b1;
      tick();
    end
    credit_in = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    xy_t        pos;
    xy_t        dest;
    msg_type_t  msg;
    direction_t route;
  } vec_t;

  vec_t vecs[5];

  // ---------------- scoreboard for random traffic ----------------
  logic [FW-1:0] exp_q[$];

  initial begin
    flit_t       f;
    logic [63:0] words[3];
    int          cnt;

    vecs[0] = '{pos: xy(2, 0),  dest: xy(5, 1),   msg: MSG_READ,  route: goEast};
    vecs[1] = '{pos: xy(2, 0),  dest: xy(0, 0),   msg: MSG_WRITE, route: goWest};
    vecs[2] = '{pos: xy(3, 3),  dest: xy(3, 7),   msg: MSG_RESP,  route: goLocal};
    vecs[3] = '{pos: xy(0, 0),  dest: xy(15, 15), msg: MSG_INV,   route: goEast};
    vecs[4] = '{pos: xy(15, 2), dest: xy(0, 2),   msg: MSG_READ,  route: goWest};

    // reset state
    rst = 1'b1;
    tick(); tick();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_flit", out_flit, 0);
    chk("rst_busy", busy, 0);
    chk("rst_credits", dbg_credit_cnt, Credits);
    rst = 1'b0;
    #1;
    chk("post_rst_req_ready", req_ready, 1);
    chk("post_rst_data_ready", data_ready, 0);

    // header-only packets from the table
    for (int i = 0; i < 5; i++) begin
      position = vecs[i].pos;
      tick(); tick();
      send_req(vecs[i].dest, vecs[i].msg, 0);
      chk("hdr_not_early", out_valid, 0);
      chk("hdr_busy", busy, 1);
      tick();
      f = exp_header(vecs[i].pos, vecs[i].dest, vecs[i].msg, vecs[i].route, 1'b1);
      chk("hdr_valid", out_valid, 1);
      chk("hdr_flit", out_flit, f);
      chk("hdr_credits", dbg_credit_cnt, Credits - 1);
      tick();
      chk("hdr_pulse", out_valid, 0);
      chk("hdr_hold", out_flit, f);
      chk("hdr_idle", busy, 0);
      return_credits(1);
      chk("hdr_credit_back", dbg_credit_cnt, Credits);
    end

    // data ignored while idle, then a 3-word packet going west
    position = xy(2, 0);
    data_valid = 1'b1;
    tick(); tick();
    chk("idle_data_ready", data_ready, 0);
    chk("idle_no_flit", out_valid, 0);
    data_valid = 1'b0;
    words[0] = 64'hAAAA_0000_1111_2222;
    words[1] = 64'hBBBB_3333_4444_5555;
    words[2] = 64'hCCCC_6666_7777_8888;
    send_req(xy(0, 0), MSG_WRITE, 3);
    chk("body_hdr_wait", data_ready, 0);
    tick();
    chk("body_hdr_valid", out_valid, 1);
    chk("body_hdr_flit", out_flit, exp_header(xy(2, 0), xy(0, 0), MSG_WRITE, goWest, 1'b0));
    for (int i = 0; i < 3; i++) begin
      push_word(words[i]);
      chk("body_valid", out_valid, 1);
      chk("body_flit", out_flit, exp_body(words[i], i == 2));
      chk("body_busy", busy, i != 2);
    end
    chk("body_credits", dbg_credit_cnt, 0);
    return_credits(4);
    chk("body_credit_back", dbg_credit_cnt, Credits);

    // credit stall: 9-flit packet with no credits returned
    reset_dut();
    position = xy(2, 0);
    tick(); tick();
    send_req(xy(4, 0), MSG_WRITE, 8);
    data_valid = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      data = {$urandom, $urandom};
      tick();
      if (out_valid) cnt++;
    end
    chk("stall_flits", cnt, 4);
    chk("stall_data_ready", data_ready, 0);
    chk("stall_credits", dbg_credit_cnt, 0);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      credit_in = (i == 0 || i == 6);
      tick();
      if (out_valid) cnt++;
    end
    credit_in = 1'b0;
    chk("stall_two_more", cnt, 2);
    chk("stall_busy", busy, 1);

    // reset in the middle of the body, right after a flit went out
    return_credits(1);
    tick();
    chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    data_valid = 1'b0;
    tick();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_credits", dbg_credit_cnt, Credits);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_req_ready", req_ready, 0);
    rst = 1'b0;
    #1;
    chk("after_rst_req_ready", req_ready, 1);
    tick(); tick();
    send_req(xy(2, 5), MSG_RESP, 0);
    tick();
    chk("clean_valid", out_valid, 1);
    chk("clean_flit", out_flit, exp_header(xy(2, 0), xy(2, 5), MSG_RESP, goLocal, 1'b1));
    chk("clean_credits", dbg_credit_cnt, Credits - 1);
    return_credits(1);

    // credit_in coincident with emission keeps the count constant
    reset_dut();
    send_req(xy(9, 0), MSG_READ, 12);
    tick();
    chk("sim_hdr", out_valid, 1);
    chk("sim_credits0", dbg_credit_cnt, Credits - 1);
    data_valid = 1'b1;
    credit_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      data = {$urandom, $urandom};
      tick();
      chk("sim_valid", out_valid, 1);
      chk("sim_credits", dbg_credit_cnt, Credits - 1);
    end
    credit_in = 1'b0;
    tick(); tick();
    data_valid = 1'b0;
    chk("sim_tail", out_flit.tail, 1);
    chk("sim_credits_end", dbg_credit_cnt, Credits - 3);
    chk("sim_idle", busy, 0);
    return_credits(3);
    chk("full_credits", dbg_credit_cnt, Credits);
    credit_in = 1'b1;
    #1;
    chk("overflow_flag", credit_overflow, 1);
    tick();
    chk("overflow_saturate", dbg_credit_cnt, Credits);
    credit_in = 1'b0;
    #1;
    chk("overflow_clear", credit_overflow, 0);

    // random traffic with a router that drains its buffer at random
    begin
      int  emitted = 0, returned = 0, router_buf = 0, remain = 0, pkts = 0;
      bit  accepted;
      xy_t rpos;
      reset_dut();
      exp_q.delete();
      rpos = xy_t'(8'($urandom_range(0, 255)));
      position = rpos;
      tick(); tick();
      for (int c = 0; c < 3000; c++) begin
        if (out_valid) begin
          emitted++;
          router_buf++;
          if (exp_q.size() == 0) chk("rand_unexpected_flit", out_flit, 0);
          else chk("rand_flit", out_flit, exp_q.pop_front());
          chk("rand_router_buf", router_buf <= Credits, 1);
        end
        chk("rand_credits", dbg_credit_cnt, Credits - emitted + returned);
        credit_in = 1'b0;
        if (router_buf > 0 && $urandom_range(0, 2) == 0) begin
          credit_in = 1'b1;
          router_buf--;
          returned++;
        end
        if (!req_valid && c < 2500 && $urandom_range(0, 3) == 0) begin
          req_valid    = 1'b1;
          req_dest     = xy_t'(8'($urandom_range(0, 255)));
          req_msg_type = msg_type_t'(2'($urandom_range(0, 3)));
          req_len      = LW'(($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, MaxLen));
        end
        data_valid = (c >= 2500) ? 1'b1 : 1'($urandom_range(0, 1));
        data = {$urandom, $urandom};
        #1;
        accepted = 1'b0;
        if (req_valid && req_ready) begin
          accepted = 1'b1;
          pkts++;
          exp_q.push_back(exp_header(rpos, req_dest, req_msg_type,
                                     spec_route(rpos, req_dest), req_len == 0));
          remain = int'(req_len);
        end
        if (data_valid && data_ready) begin
          if (remain == 0) chk("rand_spurious_data_ready", data_ready, 0);
          else begin
            exp_q.push_back(exp_body(data, remain == 1));
            remain--;
          end
        end
        tick();
        if (accepted) req_valid = 1'b0;
      end
      data_valid = 1'b0;
      credit_in = 1'b0;
      chk("rand_exp_empty", exp_q.size(), 0);
      chk("rand_remain", remain, 0);
      chk("rand_some_packets", pkts > 20, 1);
      chk("rand_end_idle", busy, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
